hazard_ctrl: RTL

Pipeline hazard controller for the 5-stage core. It drives the ID/EX register from the control side: it decides each cycle whether that register loads, holds, or loads a bubble, and it also steers PC, IF/ID and EX/MEM. It detects load-use hazards from the EX-stage copies of MRead and Rt, squashes wrong-path slots after a taken branch, freezes the pipe while data memory is busy, and aborts a memory wait that exceeds a timeout.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/sat_counter.sv | 18 +
 rtl/hazard_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage core: hazard controller states and
// register-index constants.
package cpu_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      FLUSH    = 2'd1,
      MEM_WAIT = 2'd2
   } hz_state_t;

   localparam int               REG_IDX_W = 5;
   localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Increment-enable counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clock,
   input  logic         rst_n,
   input  logic         en,
   output logic [W-1:0] count
);

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (en && (count != '1))
         count <= count + 1'b1;
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory freeze/timeout, branch squash and
// load-use stall, steering PC, IF/ID, ID/EX and EX/MEM.
module hazard_ctrl
   import cpu_pkg::*;
#(
   parameter int FLUSH_CYCLES = 1,
   parameter int TIMEOUT      = 16
) (
   input  logic                 clock,
   input  logic                 rst_n,
   input  logic                 ex_mread,
   input  logic [REG_IDX_W-1:0] ex_rt,
   input  logic [REG_IDX_W-1:0] id_rs,
   input  logic [REG_IDX_W-1:0] id_rt,
   input  logic                 id_uses_rt,
   input  logic                 ex_branch_taken,
   input  logic                 mem_busy,
   output logic                 pc_hold,
   output logic                 ifid_hold,
   output logic                 idex_hold,
   output logic                 exmem_hold,
   output logic                 idex_bubble,
   output logic                 ifid_flush,
   output logic                 mem_abort,
   output logic                 mem_error,
   output logic [31:0]          stall_cnt
);

   localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
   localparam int WW = $clog2(TIMEOUT + 1);
   localparam logic [FW-1:0] FLUSH_RELOAD = FW'(FLUSH_CYCLES - 1);
   localparam logic [WW-1:0] TIMEOUT_V    = WW'(TIMEOUT);

   hz_state_t       state, state_next, eff_state;
   logic [FW-1:0]   flush_rem, flush_rem_next;
   logic [WW-1:0]   wait_cnt, wait_cnt_next;
   logic            err_set;
   logic            freeze, abort, load_use;
   logic            pc_hold_c, ifid_hold_c, idex_hold_c, exmem_hold_c;
   logic            idex_bubble_c, ifid_flush_c, mem_abort_c;

   assign freeze   = mem_busy && (wait_cnt < TIMEOUT_V);
   assign abort    = mem_busy && !freeze;
   assign load_use = ex_mread && (ex_rt != REG_ZERO) &&
                     ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

   // Freeze beats branch squash beats load-use; leaving MEM_WAIT behaves as
   // whichever state the pipe was suspended from, decided by flush_rem.
   always_comb begin
      state_next     = state;
      eff_state      = state;
      flush_rem_next = flush_rem;
      wait_cnt_next  = wait_cnt;
      err_set        = 1'b0;
      pc_hold_c      = 1'b0;
      ifid_hold_c    = 1'b0;
      idex_hold_c    = 1'b0;
      exmem_hold_c   = 1'b0;
      idex_bubble_c  = 1'b0;
      ifid_flush_c   = 1'b0;
      mem_abort_c    = 1'b0;

      if (freeze) begin
         pc_hold_c     = 1'b1;
         ifid_hold_c   = 1'b1;
         idex_hold_c   = 1'b1;
         exmem_hold_c  = 1'b1;
         wait_cnt_next = wait_cnt + 1'b1;
         state_next    = MEM_WAIT;
      end else if (abort) begin
         mem_abort_c   = 1'b1;
         err_set       = 1'b1;
         wait_cnt_next = '0;
         state_next    = MEM_WAIT;
      end else begin
         wait_cnt_next = '0;
         if (state == MEM_WAIT)
            eff_state = (flush_rem != '0) ? FLUSH : RUN;
         case (eff_state)
            FLUSH: begin
               ifid_flush_c   = 1'b1;
               idex_bubble_c  = 1'b1;
               flush_rem_next = flush_rem - 1'b1;
               state_next     = (flush_rem == FW'(1)) ? RUN : FLUSH;
            end
            default: begin
               state_next = RUN;
               if (ex_branch_taken) begin
                  ifid_flush_c  = 1'b1;
                  idex_bubble_c = 1'b1;
                  if (FLUSH_CYCLES > 1) begin
                     flush_rem_next = FLUSH_RELOAD;
                     state_next     = FLUSH;
                  end
               end else if (load_use) begin
                  pc_hold_c     = 1'b1;
                  ifid_hold_c   = 1'b1;
                  idex_bubble_c = 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RUN;
         flush_rem <= '0;
         wait_cnt  <= '0;
         mem_error <= 1'b0;
      end else begin
         state     <= state_next;
         flush_rem <= flush_rem_next;
         wait_cnt  <= wait_cnt_next;
         mem_error <= mem_error | err_set;
      end
   end

   // Mealy outputs are forced low while reset is held so nothing leaks out.
   assign pc_hold     = rst_n & pc_hold_c;
   assign ifid_hold   = rst_n & ifid_hold_c;
   assign idex_hold   = rst_n & idex_hold_c;
   assign exmem_hold  = rst_n & exmem_hold_c;
   assign idex_bubble = rst_n & idex_bubble_c;
   assign ifid_flush  = rst_n & ifid_flush_c;
   assign mem_abort   = rst_n & mem_abort_c;

   sat_counter #(.W(32)) u_stall_cnt (
      .clock (clock),
      .rst_n (rst_n),
      .en    (pc_hold),
      .count (stall_cnt)
   );

endmodule
